// File: rtl/lifo_pkg.sv
// Shared types and helpers for the parametrised LIFO.
package lifo_pkg;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        SWAP = 2'd3
    } lifo_op_t;

    // Width of a count that must represent 0..depth inclusive.
    function automatic int lifo_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one async read port.
module lifo_mem
    import lifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = lifo_cw(DEPTH)
) (
    input  logic             c,
    input  logic             we,
    input  logic [CW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [CW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge c) begin
        if (we)
            mem[waddr[AW-1:0]] <= wdata;
    end

    // Out-of-range addresses (ptr-1 on an empty stack) read as zero.
    always_comb begin
        rdata = '0;
        if (raddr < CW'(DEPTH))
            rdata = mem[raddr[AW-1:0]];
    end

endmodule

// File: rtl/param_lifo.sv
// Parametrised LIFO with push/pop/swap, combinational peek and sticky error flags.
module param_lifo
    import lifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CW   = lifo_cw(DEPTH)
) (
    input  logic             c,
    input  logic             r,
    input  logic [WIDTH-1:0] i,
    input  logic             wr,
    input  logic             rd,
    input  logic             clr_err,
    output logic [WIDTH-1:0] o,
    output logic             o_vld,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    cnt,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);
    logic [CW-1:0]    ptr;
    logic [CW-1:0]    ptr_m1;
    logic [CW-1:0]    waddr;
    logic [WIDTH-1:0] rdata;
    logic             we;
    logic             ovf_set;
    logic             udf_set;
    lifo_op_t         op;

    assign ptr_m1 = ptr - CW'(1);
    assign cnt    = ptr;
    assign empty  = (ptr == '0);
    assign full   = (ptr == CW'(DEPTH));
    assign top    = empty ? '0 : rdata;

    // A combined request on an empty stack degrades to a plain push.
    always_comb begin
        op = NOP;
        if (wr && rd && !empty) op = SWAP;
        else if (wr)            op = PUSH;
        else if (rd)            op = POP;
    end

    assign ovf_set = (op == PUSH) && full;
    assign udf_set = (op == POP) && empty;
    assign we      = r && (((op == PUSH) && !full) || (op == SWAP));
    assign waddr   = (op == SWAP) ? ptr_m1 : ptr;

    lifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_mem (
        .c     (c),
        .we    (we),
        .waddr (waddr),
        .wdata (i),
        .raddr (ptr_m1),
        .rdata (rdata)
    );

    always_ff @(posedge c) begin
        if (!r) begin
            ptr   <= '0;
            o     <= '0;
            o_vld <= 1'b0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            o_vld <= 1'b0;
            case (op)
                PUSH: if (!full) ptr <= ptr + CW'(1);
                POP: if (!empty) begin
                    ptr   <= ptr_m1;
                    o     <= rdata;
                    o_vld <= 1'b1;
                end
                SWAP: begin
                    o     <= rdata;
                    o_vld <= 1'b1;
                end
                default: ;
            endcase
            // A new error event wins over a simultaneous clear.
            ovf <= ovf_set || (ovf && !clr_err);
            udf <= udf_set || (udf && !clr_err);
        end
    end

endmodule

// File: tb/tb_param_lifo.sv
// Self-checking bench for param_lifo against a queue-based reference model.
module tb_param_lifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             c = 1'b0;
    logic             r, wr, rd, clr_err;
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] d_o, d_top;
    logic             d_vld, d_empty, d_full, d_ovf, d_udf;
    logic [CW-1:0]    d_cnt;

    param_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .c(c), .r(r), .i(i), .wr(wr), .rd(rd), .clr_err(clr_err),
        .o(d_o), .o_vld(d_vld), .top(d_top), .cnt(d_cnt),
        .empty(d_empty), .full(d_full), .ovf(d_ovf), .udf(d_udf)
    );

    always #5 c = ~c;

    int checks = 0;
    int failures = 0;

    // Reference model: the stack is a queue whose back is the top.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_o;
    logic             m_vld, m_ovf, m_udf;

    function automatic logic [WIDTH-1:0] m_top();
        return (q.size() > 0) ? q[q.size()-1] : '0;
    endfunction

    // Drive one cycle of stimulus, advance the model, settle 1 time unit past the edge.
    task automatic cyc(input logic w, input logic p, input logic [WIDTH-1:0] d,
                       input logic clr, input logic rst_n);
        logic os, us;
        wr = w; rd = p; i = d; clr_err = clr; r = rst_n;
        @(posedge c);
        if (!rst_n) begin
            q.delete(); m_o = '0; m_vld = 0; m_ovf = 0; m_udf = 0;
        end else begin
            os = 0; us = 0; m_vld = 0;
            if (w && p && q.size() > 0) begin
                m_o = q[q.size()-1]; m_vld = 1; q[q.size()-1] = d;
            end else if (w) begin
                if (q.size() == DEPTH) os = 1; else q.push_back(d);
            end else if (p) begin
                if (q.size() == 0) us = 1;
                else begin m_o = q.pop_back(); m_vld = 1; end
            end
            m_ovf = os | (m_ovf & ~clr);
            m_udf = us | (m_udf & ~clr);
        end
        #1;
        wr = 0; rd = 0; clr_err = 0; r = 1;
    endtask

    task automatic test_reset();
        cyc(0, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        checks++; if (d_cnt !== 0 || d_empty !== 1 || d_full !== 0) begin
            failures++; $display("FAIL reset_cnt cnt=%0d empty=%b full=%b want 0/1/0", d_cnt, d_empty, d_full); end
        checks++; if (d_o !== 0 || d_vld !== 0 || d_ovf !== 0 || d_udf !== 0 || d_top !== 0) begin
            failures++; $display("FAIL reset_out o=%h vld=%b ovf=%b udf=%b top=%h want all 0", d_o, d_vld, d_ovf, d_udf, d_top); end
    endtask

    task automatic test_fill();
        logic [WIDTH-1:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, v[k], 0, 1);
            checks++; if (d_top !== v[k] || d_cnt !== CW'(k+1)) begin
                failures++; $display("FAIL fill_step%0d top=%h cnt=%0d want %h/%0d", k, d_top, d_cnt, v[k], k+1); end
        end
        checks++; if (d_cnt !== 4 || d_full !== 1 || d_top !== 8'h44 || d_ovf !== 0) begin
            failures++; $display("FAIL fill_full cnt=%0d full=%b top=%h ovf=%b want 4/1/44/0", d_cnt, d_full, d_top, d_ovf); end
    endtask

    task automatic test_overflow();
        cyc(1, 0, 8'h55, 0, 1);
        checks++; if (d_ovf !== 1 || d_cnt !== 4 || d_top !== 8'h44) begin
            failures++; $display("FAIL ovf_set ovf=%b cnt=%0d top=%h want 1/4/44", d_ovf, d_cnt, d_top); end
        cyc(0, 0, 8'h00, 1, 1);
        checks++; if (d_ovf !== 0) begin
            failures++; $display("FAIL ovf_clr ovf=%b want 0", d_ovf); end
    endtask

    task automatic test_drain();
        logic [WIDTH-1:0] v [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 8'h00, 0, 1);
            checks++; if (d_o !== v[k] || d_vld !== 1) begin
                failures++; $display("FAIL drain_pop%0d o=%h vld=%b want %h/1", k, d_o, d_vld, v[k]); end
        end
        cyc(0, 0, 8'h00, 0, 1);
        checks++; if (d_empty !== 1 || d_top !== 0 || d_vld !== 0 || d_o !== 8'h11) begin
            failures++; $display("FAIL drain_empty empty=%b top=%h vld=%b o=%h want 1/00/0/11", d_empty, d_top, d_vld, d_o); end
    endtask

    task automatic test_underflow();
        cyc(0, 1, 8'h00, 0, 1);
        checks++; if (d_udf !== 1 || d_o !== 8'h11 || d_vld !== 0 || d_cnt !== 0) begin
            failures++; $display("FAIL udf_set udf=%b o=%h vld=%b cnt=%0d want 1/11/0/0", d_udf, d_o, d_vld, d_cnt); end
        cyc(0, 1, 8'h00, 1, 1);
        checks++; if (d_udf !== 1) begin
            failures++; $display("FAIL udf_set_wins udf=%b want 1", d_udf); end
    endtask

    task automatic test_swap();
        cyc(1, 0, 8'hA0, 0, 1);
        cyc(1, 1, 8'hB0, 0, 1);
        checks++; if (d_o !== 8'hA0 || d_vld !== 1 || d_cnt !== 1 || d_top !== 8'hB0) begin
            failures++; $display("FAIL swap o=%h vld=%b cnt=%0d top=%h want a0/1/1/b0", d_o, d_vld, d_cnt, d_top); end
        cyc(0, 1, 8'h00, 0, 1);
        checks++; if (d_o !== 8'hB0 || d_empty !== 1) begin
            failures++; $display("FAIL swap_pop o=%h empty=%b want b0/1", d_o, d_empty); end
        cyc(1, 1, 8'hC0, 0, 1);
        checks++; if (d_cnt !== 1 || d_top !== 8'hC0 || d_vld !== 0 || d_udf !== m_udf) begin
            failures++; $display("FAIL swap_empty cnt=%0d top=%h vld=%b udf=%b want 1/c0/0/%b", d_cnt, d_top, d_vld, d_udf, m_udf); end
        // Swap while full must not flag overflow.
        for (int k = 0; k < 3; k++) cyc(1, 0, 8'hD0 + 8'(k), 0, 1);
        cyc(1, 1, 8'hE0, 0, 1);
        checks++; if (d_o !== 8'hD2 || d_top !== 8'hE0 || d_cnt !== 4 || d_ovf !== 0) begin
            failures++; $display("FAIL swap_full o=%h top=%h cnt=%0d ovf=%b want d2/e0/4/0", d_o, d_top, d_cnt, d_ovf); end
    endtask

    task automatic test_reset_mid();
        cyc(0, 1, 8'h00, 0, 1);
        checks++; if (d_cnt !== 3) begin
            failures++; $display("FAIL mid_prep cnt=%0d want 3", d_cnt); end
        cyc(1, 0, 8'h77, 0, 0);
        checks++; if (d_cnt !== 0 || d_empty !== 1 || d_o !== 0 || d_vld !== 0 || d_ovf !== 0 || d_udf !== 0) begin
            failures++; $display("FAIL mid_reset cnt=%0d empty=%b o=%h vld=%b ovf=%b udf=%b want 0/1/00/0/0/0",
                                 d_cnt, d_empty, d_o, d_vld, d_ovf, d_udf); end
        cyc(1, 0, 8'h5A, 0, 1);
        checks++; if (d_top !== 8'h5A || d_cnt !== 1) begin
            failures++; $display("FAIL mid_push top=%h cnt=%0d want 5a/1", d_top, d_cnt); end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) != 0));
            checks++;
            if (d_o !== m_o || d_vld !== m_vld || d_top !== m_top() || d_cnt !== CW'(q.size()) ||
                d_empty !== (q.size() == 0) || d_full !== (q.size() == DEPTH) ||
                d_ovf !== m_ovf || d_udf !== m_udf) begin
                failures++;
                if (bad++ < 10)
                    $display("FAIL rand_%0d o=%h/%h vld=%b/%b top=%h/%h cnt=%0d/%0d ovf=%b/%b udf=%b/%b (got/want)",
                             n, d_o, m_o, d_vld, m_vld, d_top, m_top(), d_cnt, q.size(),
                             d_ovf, m_ovf, d_udf, m_udf);
            end
        end
    endtask

    initial begin
        r = 1; wr = 0; rd = 0; clr_err = 0; i = '0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_swap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
